ft6206_i2c_target: RTL

FT6206_I2C_TARGET -- requirements
Module: ft6206_i2c_target

---
 rtl/ft6206_defines.sv | 60 ++++++
 rtl/i2c_line_sync.sv | 46 ++++
 rtl/ft6206_i2c_target.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ft6206_defines.sv
// rtl/ft6206_defines.sv - shared types, register map and read mux for the FT6206 target
package ft6206_defines;

    typedef struct packed {
        logic        valid;
        logic [11:0] x;
        logic [11:0] y;
    } touch_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK
    } state_t;

    localparam logic [7:0] REG_TD_STATUS = 8'h02;
    localparam logic [7:0] REG_P1_XH     = 8'h03;
    localparam logic [7:0] REG_P1_XL     = 8'h04;
    localparam logic [7:0] REG_P1_YH     = 8'h05;
    localparam logic [7:0] REG_P1_YL     = 8'h06;
    localparam logic [7:0] REG_P2_XH     = 8'h09;
    localparam logic [7:0] REG_P2_XL     = 8'h0A;
    localparam logic [7:0] REG_P2_YH     = 8'h0B;
    localparam logic [7:0] REG_P2_YL     = 8'h0C;
    localparam logic [7:0] REG_TH_GROUP  = 8'h80;
    localparam logic [7:0] REG_CHIP_ID   = 8'hA3;
    localparam logic [7:0] REG_VENDOR_ID = 8'hA8;
    localparam logic [7:0] CHIP_ID       = 8'h06;
    localparam logic [7:0] VENDOR_ID     = 8'h11;

    // idx: 0 = evt/x hi, 1 = x lo, 2 = id/y hi, 3 = y lo; invalid points read as zero coords
    function automatic logic [7:0] point_reg(input touch_t p, input logic [3:0] id,
                                             input logic [1:0] idx);
        logic [11:0] x;
        logic [11:0] y;
        x = p.valid ? p.x : 12'h000;
        y = p.valid ? p.y : 12'h000;
        case (idx)
            2'd0:    point_reg = {(p.valid ? 2'b10 : 2'b01), 2'b00, x[11:8]};
            2'd1:    point_reg = x[7:0];
            2'd2:    point_reg = {id, y[11:8]};
            default: point_reg = y[7:0];
        endcase
    endfunction

    function automatic logic [7:0] read_reg(input logic [7:0] addr, input touch_t p1,
                                            input touch_t p2, input logic [7:0] thresh);
        case (addr)
            REG_TD_STATUS: read_reg = {6'b0, {1'b0, p1.valid} + {1'b0, p2.valid}};
            REG_P1_XH, REG_P1_XL, REG_P1_YH, REG_P1_YL:
                read_reg = point_reg(p1, 4'h0, addr[1:0] - 2'd3);
            REG_P2_XH, REG_P2_XL, REG_P2_YH, REG_P2_YL:
                read_reg = point_reg(p2, 4'h1, addr[1:0] - 2'd1);
            REG_TH_GROUP:  read_reg = thresh;
            REG_CHIP_ID:   read_reg = CHIP_ID;
            REG_VENDOR_ID: read_reg = VENDOR_ID;
            default:       read_reg = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with START, STOP and SCL edge detection
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                scl_ff[i] <= scl_ff[i-1];
                sda_ff[i] <= sda_ff[i-1];
            end
            scl_ff[0] <= scl;
            sda_ff[0] <= sda;
            scl_q     <= scl_s;
            sda_q     <= sda_s;
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/ft6206_i2c_target.sv
// rtl/ft6206_i2c_target.sv - FT6206-compatible I2C touch controller target
module ft6206_i2c_target
    import ft6206_defines::*;
#(
    parameter logic [6:0] ADDR        = 7'h38,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        p1_valid,
    input  logic [11:0] p1_x,
    input  logic [11:0] p1_y,
    input  logic        p2_valid,
    input  logic [11:0] p2_x,
    input  logic [11:0] p2_y,
    output logic        busy,
    output logic [7:0]  thresh
);
    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] rx, rx_next, tx, ptr, rd_byte;
    logic       rw, rack_ack, byte_done;
    touch_t     p1_shadow, p2_shadow;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_next   = {rx[6:0], sda_s};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);
    assign rd_byte   = read_reg(ptr, p1_shadow, p2_shadow, thresh);

    // ACK states drive SDA on the first SCL fall and release on the second
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            ptr       <= 8'h00;
            thresh    <= 8'h80;
            p1_shadow <= '0;
            p2_shadow <= '0;
            bit_cnt   <= 4'd0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            rw        <= 1'b0;
            rack_ack  <= 1'b0;
        end else if (start_det) begin
            state     <= ST_ADDR;
            bit_cnt   <= 4'd0;
            sda_oe    <= 1'b0;
            p1_shadow <= {p1_valid, p1_x, p1_y};
            p2_shadow <= {p2_valid, p2_x, p2_y};
        end else if (stop_det) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (scl_rise) begin
                rx      <= rx_next;
                bit_cnt <= bit_cnt + 4'd1;
            end
            case (state)
                ST_ADDR: if (byte_done) begin
                    bit_cnt <= 4'd0;
                    if (rx_next[7:1] == ADDR) begin
                        state <= ST_ADDR_ACK;
                        rw    <= rx_next[0];
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_PTR: if (byte_done) begin
                    bit_cnt <= 4'd0;
                    ptr     <= rx_next;
                    state   <= ST_PTR_ACK;
                end
                ST_WDATA: if (byte_done) begin
                    bit_cnt <= 4'd0;
                    if (ptr == REG_TH_GROUP) thresh <= rx_next;
                    ptr   <= ptr + 8'd1;
                    state <= ST_WDATA_ACK;
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    bit_cnt <= 4'd0;
                    if (!sda_oe) begin
                        sda_oe <= 1'b1;
                    end else if (state == ST_ADDR_ACK && rw) begin
                        state  <= ST_RDATA;
                        tx     <= {rd_byte[6:0], 1'b0};
                        sda_oe <= ~rd_byte[7];
                        ptr    <= ptr + 8'd1;
                    end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ST_RACK;
                    end else begin
                        sda_oe <= ~tx[7];
                        tx     <= {tx[6:0], 1'b0};
                    end
                end
                ST_RACK: begin
                    if (scl_rise) rack_ack <= ~sda_s;
                    if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt <= 4'd0;
                        if (rack_ack) begin
                            state  <= ST_RDATA;
                            tx     <= {rd_byte[6:0], 1'b0};
                            sda_oe <= ~rd_byte[7];
                            ptr    <= ptr + 8'd1;
                        end else begin
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
